// File: rtl/matmul_pkg.sv
// Shared definitions for the 2x2 matrix-multiply scheduler: FSM state
// encoding, default byte width, derived accumulator width and frame sizes.
package matmul_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ACC_W_DEF  = 2 * DATA_W_DEF + 1;
    localparam int N_OPND     = 8;   // A0..A3, B0..B3
    localparam int N_RES      = 4;   // C00, C01, C10, C11

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_EMIT    = 2'd2
    } state_t;

endpackage

// File: rtl/matmul_mac.sv
// Shared multiply-accumulate slice: one DATA_W x DATA_W multiplier and the
// adder that either passes the product through (first partial product of a
// dot product) or adds it to the running accumulator (second one).
// Purely combinational.
module matmul_mac #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 2 * DATA_W + 1
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [ACC_W-1:0]  acc,
    input  logic              t,
    output logic [ACC_W-1:0]  p,
    output logic [ACC_W-1:0]  mac_res
);

    logic [2*DATA_W-1:0] prod;

    // Full-precision product, zero-extended to the accumulator width.
    always_comb begin
        prod = a * b;
        p    = {{(ACC_W - 2 * DATA_W){1'b0}}, prod};
    end

    // t=0 starts a new dot product, t=1 completes it.
    always_comb begin
        mac_res = t ? (acc + p) : p;
    end

endmodule

// File: rtl/matmul_mac_sched.sv
// Time-multiplexed 2x2 matrix-multiply scheduler.
// Loads eight operand bytes (A0..A3, B0..B3), runs one shared MAC through the
// eight partial products, then streams C00, C01, C10, C11.
// Build option: MATMUL_SAT_EN saturates out_data to 2^DATA_W-1 on overflow;
// without it out_data is the truncated low byte. out_ovf is the same in both.
//
// Handshakes: a byte moves on a stream at a rising edge where valid && ready
// are both high; a valid holder keeps data/valid stable until that edge, and
// ready never depends on valid. clr overrides any handshake in its cycle.
module matmul_mac_sched
    import matmul_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = 2 * DATA_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_ovf,
    output logic              busy,
    output state_t            state_dbg
);

    state_t              state_q, state_d;
    logic [2:0]          in_cnt_q;
    logic [2:0]          k_q;
    logic [1:0]          out_cnt_q;
    logic [DATA_W-1:0]   opnd_q [N_OPND];
    logic [ACC_W-1:0]    res_q  [N_RES];
    logic [ACC_W-1:0]    acc_q;

    logic                in_fire;
    logic                out_fire;
    logic                comp_step;
    logic [DATA_W-1:0]   mac_a;
    logic [DATA_W-1:0]   mac_b;
    logic [ACC_W-1:0]    mac_p;
    logic [ACC_W-1:0]    mac_res;
    logic [ACC_W-1:0]    res_cur;
    logic                res_big;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs; unknown encodings fall back to LOAD.
    always_comb begin
        state_d   = ST_LOAD;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            ST_LOAD: begin
                in_ready = 1'b1;
                state_d  = ST_LOAD;
                if (in_valid && (in_cnt_q == 3'd7)) begin
                    state_d = ST_COMPUTE;
                end
            end
            ST_COMPUTE: begin
                busy    = 1'b1;
                state_d = (k_q == 3'd7) ? ST_EMIT : ST_COMPUTE;
            end
            ST_EMIT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                state_d   = ST_EMIT;
                if (out_ready && (out_cnt_q == 2'd3)) begin
                    state_d = ST_LOAD;
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
        if (clr) begin
            state_d = ST_LOAD;
        end
    end

    // Qualified transfer/step strobes; clr suppresses all of them.
    always_comb begin
        in_fire   = in_valid && in_ready && !clr;
        out_fire  = out_valid && out_ready && !clr;
        comp_step = (state_q == ST_COMPUTE) && !clr;
    end

    // Operand selection for step k: i=k[2], j=k[1], t=k[0];
    // p = A[2i+t] * B[2t+j].
    always_comb begin
        mac_a = opnd_q[{k_q[2], k_q[0]}];
        mac_b = opnd_q[4 + {k_q[0], k_q[1]}];
    end

    matmul_mac #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .a       (mac_a),
        .b       (mac_b),
        .acc     (acc_q),
        .t       (k_q[0]),
        .p       (mac_p),
        .mac_res (mac_res)
    );

    // Frame counters: input slot, compute step and output index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_cnt_q  <= '0;
            k_q       <= '0;
            out_cnt_q <= '0;
        end else if (clr) begin
            in_cnt_q  <= '0;
            k_q       <= '0;
            out_cnt_q <= '0;
        end else begin
            if (in_fire) begin
                in_cnt_q <= in_cnt_q + 3'd1;   // wraps 7 -> 0 on the last byte
            end
            if (comp_step) begin
                k_q <= k_q + 3'd1;             // wraps 7 -> 0 entering EMIT
            end
            if (out_fire) begin
                out_cnt_q <= out_cnt_q + 2'd1; // wraps 3 -> 0 leaving EMIT
            end
        end
    end

    // Operand register file; clr leaves contents untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < N_OPND; n++) begin
                opnd_q[n] <= '0;
            end
        end else if (in_fire) begin
            opnd_q[in_cnt_q] <= in_data;
        end
    end

    // Accumulator and result registers, written during COMPUTE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            for (int n = 0; n < N_RES; n++) begin
                res_q[n] <= '0;
            end
        end else if (comp_step) begin
            if (k_q[0] == 1'b0) begin
                acc_q <= mac_res;
            end else begin
                res_q[{k_q[2], k_q[1]}] <= mac_res;
            end
        end
    end

    // Output byte and overflow flag, derived from the registered result.
    always_comb begin
        res_cur = res_q[out_cnt_q];
        res_big = |res_cur[ACC_W-1:DATA_W];
        out_ovf = (state_q == ST_EMIT) && res_big;
`ifdef MATMUL_SAT_EN
        out_data = res_big ? {DATA_W{1'b1}} : res_cur[DATA_W-1:0];
`else
        out_data = res_cur[DATA_W-1:0];
`endif
    end

    // Debug view of the FSM.
    always_comb begin
        state_dbg = state_q;
    end

endmodule

// File: tb/tb_matmul_mac_sched.sv
// Self-checking bench for matmul_mac_sched: drives operand frames, computes
// expected products with a plain 2x2 matrix multiply and compares the
// output stream, flags and timing.
module tb_matmul_mac_sched;
    import matmul_pkg::*;

    localparam int DW = 8;
    localparam int AW = 2 * DW + 1;

    logic          clk;
    logic          rst;
    logic          clr;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_ovf;
    logic          busy;
    state_t        state_dbg;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int hs_cnt = 0;

    logic [DW-1:0] fr [8];
    logic [AW-1:0] exp_q [$];

    matmul_mac_sched dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ovf   (out_ovf),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (out_valid && out_ready && !clr && !rst) hs_cnt <= hs_cnt + 1;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // reference model: C = A x B with A, B row-major 2x2
    task automatic model_frame();
        int c;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                c = 0;
                for (int t = 0; t < 2; t++) c += int'(fr[2*i+t]) * int'(fr[4+2*t+j]);
                exp_q.push_back(AW'(c));
            end
        end
    endtask

    function automatic logic [DW-1:0] exp_byte(input logic [AW-1:0] c);
`ifdef MATMUL_SAT_EN
        return (c > 255) ? 8'hFF : c[DW-1:0];
`else
        return c[DW-1:0];
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // driver: send the first n bytes of fr, in_valid held across bytes
    task automatic send_frame(input int n);
        int w;
        for (int s = 0; s < n; s++) begin
            in_data  = fr[s];
            in_valid = 1'b1;
            w = 0;
            while (!in_ready && w < 200) begin
                tick();
                w++;
            end
            if (!in_ready) check("in_ready_timeout", 0, 1);
            tick();
        end
        in_valid = 1'b0;
        acc_cyc  = cyc;
    endtask

    // receiver: four result bytes, optional stall before each handshake
    task automatic recv_frame(input int stall, input bit chk_lat);
        int w;
        logic [AW-1:0] c;
        logic [DW-1:0] held;
        logic          held_ovf;
        int hs0;
        hs0 = hs_cnt;
        for (int n = 0; n < 4; n++) begin
            c = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            out_ready = (stall == 0);
            w = 0;
            while (!out_valid && w < 200) begin
                tick();
                w++;
            end
            if (!out_valid) begin
                check("out_valid_timeout", 0, 1);
                out_ready = 1'b1;
                return;
            end
            if (n == 0 && chk_lat) check("latency_edges", cyc - acc_cyc, 8);
            if (stall > 0) begin
                held     = out_data;
                held_ovf = out_ovf;
                for (int s = 0; s < stall; s++) begin
                    tick();
                    check("hold_valid", out_valid, 1);
                    check("hold_data", out_data, held);
                    check("hold_ovf", out_ovf, held_ovf);
                end
                out_ready = 1'b1;
            end
            check("out_data", out_data, exp_byte(c));
            check("out_ovf", out_ovf, (c > 255) ? 1 : 0);
            tick();
        end
        check("in_ready_after_emit", in_ready, 1);
        check("out_valid_after_emit", out_valid, 0);
        check("handshakes", hs_cnt - hs0, 4);
    endtask

    task automatic set_frame(input int a0, a1, a2, a3, b0, b1, b2, b3);
        fr[0] = DW'(a0); fr[1] = DW'(a1); fr[2] = DW'(a2); fr[3] = DW'(a3);
        fr[4] = DW'(b0); fr[5] = DW'(b1); fr[6] = DW'(b2); fr[7] = DW'(b3);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_out_ovf"}, out_ovf, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) tick();
        check_reset_vals("rst");
        rst = 1'b0;
        tick();
        check_reset_vals("post_rst");

        // basic frame, ready tied high, latency checked
        set_frame(1, 2, 3, 4, 5, 6, 7, 8);
        model_frame();
        send_frame(8);
        check("busy_compute", busy, 1);
        check("in_ready_compute", in_ready, 0);
        recv_frame(0, 1);

        // all 0xFF: overflow on every result
        set_frame(255, 255, 255, 255, 255, 255, 255, 255);
        model_frame();
        send_frame(8);
        recv_frame(0, 1);

        // same basic frame with consumer stalls
        set_frame(1, 2, 3, 4, 5, 6, 7, 8);
        model_frame();
        send_frame(8);
        recv_frame(5, 0);
        repeat (3) tick();
        check("no_extra_valid", out_valid, 0);

        // junk on in_valid while busy must not be captured
        set_frame(200, 17, 99, 3, 45, 250, 1, 128);
        model_frame();
        send_frame(8);
        in_valid = 1'b1;
        in_data  = DW'($urandom_range(0, 255));
        recv_frame(0, 1);
        in_valid = 1'b0;
        set_frame(1, 0, 0, 1, 9, 8, 7, 6);
        model_frame();
        send_frame(8);
        recv_frame(0, 1);

        // clr after 5 input bytes, then a fresh frame
        set_frame(77, 88, 99, 111, 122, 133, 144, 155);
        send_frame(5);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_load_in_ready", in_ready, 1);
        set_frame(2, 3, 4, 5, 6, 7, 8, 9);
        model_frame();
        send_frame(8);
        recv_frame(0, 1);

        // clr during EMIT after C00
        set_frame(10, 20, 30, 40, 50, 60, 70, 80);
        model_frame();
        send_frame(8);
        while (!out_valid && cyc - acc_cyc < 50) tick();
        check("emit_c00", out_data, exp_byte(exp_q[0]));
        tick();                      // C00 handshake
        clr = 1'b1;
        out_ready = 1'b0;
        tick();
        clr = 1'b0;
        check("clr_emit_out_valid", out_valid, 0);
        check("clr_emit_in_ready", in_ready, 1);
        check("clr_emit_busy", busy, 0);
        exp_q.delete();
        out_ready = 1'b1;

        // rst asserted at compute step k=3
        set_frame(5, 6, 7, 8, 9, 10, 11, 12);
        send_frame(8);
        tick(); tick(); tick();
        rst = 1'b1;
        #1;
        check_reset_vals("rst_mid");
        tick();
        check_reset_vals("rst_mid_hold");
        rst = 1'b0;
        tick();

        // randomized frames with random stalls
        for (int f = 0; f < 6; f++) begin
            for (int s = 0; s < 8; s++) fr[s] = DW'($urandom_range(0, 255));
            model_frame();
            send_frame(8);
            recv_frame($urandom_range(0, 3), 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
